seed_enable_sequencer: RTL and testbench
========================================

// Module: seed_enable_sequencer
// PURPOSE
// - Sequences seed-laser turn-on: DAC gain load -> DDS config load -> settle -> laser enable.
// - Watches over-current and handshake timeouts, and latches faults until explicitly cleared.
// - Sits between the I2C register file (enable/clear controls) and the DAC/DDS SPI engines.
// - Drives the laser enable that feeds the seed_laser_disable/LED logic.
// PARAMETERS
// - CNT_W           16     width of the shared settle/timeout counter
// - SETTLE_CYCLES   10000  cycles held in SETTLE before enable (1 ms at 10 MHz); must be < 2**CNT_W
// - TIMEOUT_CYCLES  1000   max cycles waiting for a *_done pulse before fault; must be < 2**CNT_W
// PORTS
// - clk            in   1  system clock (10 MHz domain)
// - rst            in   1  synchronous reset, active-high
// - enable_req     in   1  level; 1 = laser requested on
// - fault_clear    in   1  single-cycle pulse; clears a latched fault
// - over_current   in   1  level from the ADC monitor; 1 = current limit exceeded
// - dac_done       in   1  single-cycle pulse; DAC gain write complete
// - dds_done       in   1  single-cycle pulse; DDS control write complete
// - dac_update_req out  1  single-cycle pulse; starts the DAC gain write
// - dds_update_req out  1  single-cycle pulse; starts the DDS control write
// - laser_enable   out  1  registered; 1 only in ACTIVE
// - fault_latched  out  1  registered; 1 in FAULT
// - fault_code     out  2  00 none, 01 over-current, 10 DAC timeout, 11 DDS timeout
// - seq_state      out  3  current state encoding (status readback)
// BEHAVIOUR
// - Reset: state IDLE, counter 0, and every output 0 (fault_code 00, seq_state 000).
// - Reset mid-sequence aborts immediately; no request pulse is issued on the reset cycle.
// - States and encodings:
//   - IDLE=0, CFG_DAC=1, WAIT_DAC=2, CFG_DDS=3, WAIT_DDS=4, SETTLE=5, ACTIVE=6, FAULT=7.
// - IDLE:
//   - enable_req=1 and over_current=0 -> CFG_DAC.
//   - over_current=1 -> FAULT, code 01.
// - CFG_DAC: dac_update_req=1 for exactly this cycle; counter<=0; -> WAIT_DAC.
// - WAIT_DAC:
//   - dac_done -> CFG_DDS.
//   - Otherwise, counter==TIMEOUT_CYCLES-1 -> FAULT, code 10.
// - CFG_DDS: dds_update_req=1 for one cycle; counter<=0; -> WAIT_DDS.
// - WAIT_DDS:
//   - dds_done -> SETTLE (counter<=0).
//   - Timeout -> FAULT, code 11.
// - SETTLE: counter==SETTLE_CYCLES-1 -> ACTIVE.
// - ACTIVE: laser_enable=1; stays while enable_req=1 and over_current=0.
// - Latency:
//   - enable_req rise in IDLE -> dac_update_req high 2 cycles later (IDLE->CFG_DAC edge, then pulse).
//   - laser_enable rises on the edge entering ACTIVE.
// - Priority in every non-FAULT state, highest first:
//   - over_current -> FAULT/01.
//   - enable_req=0 -> IDLE (laser_enable=0 next edge; no fault).
//   - timeout.
//   - normal progression.
// - Simultaneous events:
//   - done and timeout on the same cycle: done wins.
//   - done and over_current on the same cycle: over_current wins.
// - laser_enable drops on the same edge that leaves ACTIVE (1-cycle response to over_current).
// - FAULT:
//   - fault_latched=1; fault_code holds the first cause (later causes do not overwrite).
//   - Exit to IDLE only on fault_clear=1 with over_current=0 and enable_req=0.
//   - fault_clear with either condition true is ignored; a new pulse is required.
// - On entering IDLE from FAULT: fault_code <= 00.
// - Counter saturates, never wraps; it is reset on every CFG_* and SETTLE entry.
// - *_done pulses arriving outside the matching WAIT state are ignored.
// STRUCTURE
// - Shared package seed_pkg holds:
//   - State localparams (SEQ_IDLE..SEQ_FAULT).
//   - FAULT_* code localparams.
//   - The default SETTLE/TIMEOUT cycle counts.
// - One sub-module, seq_timer: loadable up-counter with clear, terminal-compare and saturate, CNT_W wide.
// - FSM and output registers stay in this module.
// TESTING
// - Nominal turn-on:
//   - Stimulus: enable_req=1; dac_done 5 cycles after the req; dds_done 7 cycles after the req.
//   - Response: one pulse each; laser_enable=1 exactly SETTLE_CYCLES after dds_done; seq_state=6.
// - DAC timeout:
//   - Stimulus: no dac_done.
//   - Response: FAULT at cycle TIMEOUT_CYCLES after the req; fault_code=10; laser_enable stays 0; dds_update_req never pulses.
// - Over-current while ACTIVE:
//   - Response: laser_enable=0 on the next edge; fault_code=01.
//   - Follow-up: fault_clear with enable_req=1 is ignored; after enable_req=0 a new clear returns to IDLE with code 00.
// - Simultaneity:
//   - dac_done on the timeout cycle -> proceeds to CFG_DDS.
//   - dds_done plus over_current on the same cycle -> FAULT/01.
// - Abort and reset:
//   - enable_req=0 in SETTLE -> IDLE, no fault.
//   - rst=1 in WAIT_DDS -> all outputs 0 next edge; a late dds_done is ignored.

Source files
------------

// File: rtl/seed_enable_sequencer_pkg.sv
// seed_pkg: shared state encodings, fault codes and default timing for the seed-laser sequencer.
package seed_pkg;

    localparam int CNT_W_DEF          = 16;
    localparam int SETTLE_CYCLES_DEF  = 10000;
    localparam int TIMEOUT_CYCLES_DEF = 1000;

    localparam logic [2:0] SEQ_IDLE     = 3'd0;
    localparam logic [2:0] SEQ_CFG_DAC  = 3'd1;
    localparam logic [2:0] SEQ_WAIT_DAC = 3'd2;
    localparam logic [2:0] SEQ_CFG_DDS  = 3'd3;
    localparam logic [2:0] SEQ_WAIT_DDS = 3'd4;
    localparam logic [2:0] SEQ_SETTLE   = 3'd5;
    localparam logic [2:0] SEQ_ACTIVE   = 3'd6;
    localparam logic [2:0] SEQ_FAULT    = 3'd7;

    localparam logic [1:0] FAULT_NONE = 2'b00;
    localparam logic [1:0] FAULT_OC   = 2'b01;
    localparam logic [1:0] FAULT_DAC  = 2'b10;
    localparam logic [1:0] FAULT_DDS  = 2'b11;

endpackage

// File: rtl/seed_enable_sequencer_timer.sv
// seq_timer: loadable saturating up-counter with clear and terminal-count compare.
module seq_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             inc,
    input  logic [CNT_W-1:0] term,
    output logic             hit
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (inc && count != '1)
            count <= count + CNT_W'(1);
    end

    assign hit = count == term;

endmodule

// File: rtl/seed_enable_sequencer.sv
// seed_enable_sequencer: DAC gain load -> DDS config load -> settle -> laser enable, with latched faults.
module seed_enable_sequencer
    import seed_pkg::*;
#(
    parameter int CNT_W          = CNT_W_DEF,
    parameter int SETTLE_CYCLES  = SETTLE_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable_req,
    input  logic       fault_clear,
    input  logic       over_current,
    input  logic       dac_done,
    input  logic       dds_done,
    output logic       dac_update_req,
    output logic       dds_update_req,
    output logic       laser_enable,
    output logic       fault_latched,
    output logic [1:0] fault_code,
    output logic [2:0] seq_state
);

    localparam logic [CNT_W-1:0] SETTLE_TERM  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_TERM = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]       state, next;
    logic [1:0]       cause;
    logic [CNT_W-1:0] term;
    logic             hit, clr;

    // one shared counter: timeout in the WAIT states, settle time in SETTLE
    assign term = (state == SEQ_SETTLE) ? SETTLE_TERM : TIMEOUT_TERM;
    assign clr  = state == SEQ_CFG_DAC || state == SEQ_CFG_DDS || (state != SEQ_SETTLE && next == SEQ_SETTLE);

    seq_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .load     (1'b0),
        .load_val ('0),
        .inc      (1'b1),
        .term     (term),
        .hit      (hit)
    );

    // done beats a coincident timeout; over_current and enable drop beat everything
    always_comb begin
        next  = state;
        cause = FAULT_NONE;
        if (state == SEQ_FAULT)
            next = (fault_clear && !over_current && !enable_req) ? SEQ_IDLE : SEQ_FAULT;
        else if (over_current) begin
            next  = SEQ_FAULT;
            cause = FAULT_OC;
        end
        else if (!enable_req)
            next = SEQ_IDLE;
        else
            case (state)
                SEQ_IDLE:     next = SEQ_CFG_DAC;
                SEQ_CFG_DAC:  next = SEQ_WAIT_DAC;
                SEQ_WAIT_DAC: begin
                    next  = dac_done ? SEQ_CFG_DDS : hit ? SEQ_FAULT : SEQ_WAIT_DAC;
                    cause = (!dac_done && hit) ? FAULT_DAC : FAULT_NONE;
                end
                SEQ_CFG_DDS:  next = SEQ_WAIT_DDS;
                SEQ_WAIT_DDS: begin
                    next  = dds_done ? SEQ_SETTLE : hit ? SEQ_FAULT : SEQ_WAIT_DDS;
                    cause = (!dds_done && hit) ? FAULT_DDS : FAULT_NONE;
                end
                SEQ_SETTLE:   next = hit ? SEQ_ACTIVE : SEQ_SETTLE;
                default:      next = state;
            endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= SEQ_IDLE;
            dac_update_req <= 1'b0;
            dds_update_req <= 1'b0;
            laser_enable   <= 1'b0;
            fault_latched  <= 1'b0;
            fault_code     <= FAULT_NONE;
        end else begin
            state          <= next;
            dac_update_req <= state == SEQ_CFG_DAC && next == SEQ_WAIT_DAC;
            dds_update_req <= state == SEQ_CFG_DDS && next == SEQ_WAIT_DDS;
            laser_enable   <= next == SEQ_ACTIVE;
            fault_latched  <= next == SEQ_FAULT;
            fault_code     <= (state == SEQ_FAULT) ? ((next == SEQ_IDLE) ? FAULT_NONE : fault_code) : cause;
        end
    end

    assign seq_state = state;

endmodule

// File: tb/tb_seed_enable_sequencer.sv
// tb_seed_enable_sequencer: table vectors, directed corner sequences and random stimulus vs a phase/age model.
module tb_seed_enable_sequencer;

    localparam int ST = 20;
    localparam int TO = 12;

    logic       clk = 1'b0;
    logic       rst = 1'b0, enable_req = 1'b0, fault_clear = 1'b0, over_current = 1'b0;
    logic       dac_done = 1'b0, dds_done = 1'b0;
    logic       dac_update_req, dds_update_req, laser_enable, fault_latched;
    logic [1:0] fault_code;
    logic [2:0] seq_state;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int n_dacp = 0;
    int n_ddsp = 0;

    always #5 clk = ~clk;

    seed_enable_sequencer #(.CNT_W(16), .SETTLE_CYCLES(ST), .TIMEOUT_CYCLES(TO)) dut (
        .clk            (clk),
        .rst            (rst),
        .enable_req     (enable_req),
        .fault_clear    (fault_clear),
        .over_current   (over_current),
        .dac_done       (dac_done),
        .dds_done       (dds_done),
        .dac_update_req (dac_update_req),
        .dds_update_req (dds_update_req),
        .laser_enable   (laser_enable),
        .fault_latched  (fault_latched),
        .fault_code     (fault_code),
        .seq_state      (seq_state)
    );

    // reference: named phases plus the number of edges spent in the current phase
    typedef enum int {M_OFF, M_DAC_GO, M_DAC_WAIT, M_DDS_GO, M_DDS_WAIT, M_SETTLE, M_ON, M_TRIP} mph_t;
    mph_t       ph = M_OFF;
    int         age = 0;
    logic       m_laser = 1'b0, m_lat = 1'b0, m_dacp = 1'b0, m_ddsp = 1'b0;
    logic [1:0] m_code = 2'b00;

    task automatic model_step(input logic r, en, fc, oc, dd, sd);
        mph_t nx = ph;
        m_dacp = 1'b0;
        m_ddsp = 1'b0;
        if (r) begin
            ph = M_OFF; age = 0; m_code = 2'b00; m_laser = 1'b0; m_lat = 1'b0;
            return;
        end
        if (ph == M_TRIP) begin
            if (fc && !oc && !en) begin nx = M_OFF; m_code = 2'b00; end
        end else if (oc) begin
            nx = M_TRIP; m_code = 2'b01;
        end else if (!en) begin
            nx = M_OFF;
        end else begin
            case (ph)
                M_OFF:      nx = M_DAC_GO;
                M_DAC_GO:   begin nx = M_DAC_WAIT; m_dacp = 1'b1; end
                M_DAC_WAIT: if (dd) nx = M_DDS_GO; else if (age + 1 >= TO) begin nx = M_TRIP; m_code = 2'b10; end
                M_DDS_GO:   begin nx = M_DDS_WAIT; m_ddsp = 1'b1; end
                M_DDS_WAIT: if (sd) nx = M_SETTLE; else if (age + 1 >= TO) begin nx = M_TRIP; m_code = 2'b11; end
                M_SETTLE:   if (age + 1 >= ST) nx = M_ON;
                default:    nx = ph;
            endcase
        end
        age = (nx == ph) ? age + 1 : 0;
        ph = nx;
        m_laser = ph == M_ON;
        m_lat = ph == M_TRIP;
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, got, exp);
        end
    endtask

    task automatic cycle(input logic r, en, fc, oc, dd, sd);
        logic [8:0] got, exp;
        @(negedge clk);
        rst = r; enable_req = en; fault_clear = fc; over_current = oc; dac_done = dd; dds_done = sd;
        @(posedge clk);
        model_step(r, en, fc, oc, dd, sd);
        #1;
        cyc++;
        n_dacp += int'(dac_update_req);
        n_ddsp += int'(dds_update_req);
        got = {laser_enable, fault_latched, fault_code, seq_state, dac_update_req, dds_update_req};
        exp = {m_laser, m_lat, m_code, 3'(ph), m_dacp, m_ddsp};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL model cyc=%0d got=%b exp=%b (laser,lat,code,state,dacp,ddsp)", cyc, got, exp);
        end
    endtask

    task automatic step(input logic en, fc, oc, dd, sd);
        cycle(1'b0, en, fc, oc, dd, sd);
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_dacp = 0;
        n_ddsp = 0;
    endtask

    // req edge, dac_done on the 5th edge, dds_done on the 7th, then full settle
    task automatic go_active();
        for (int i = 1; i <= 7; i++) step(1'b1, 1'b0, 1'b0, i == 5, i == 7);
        for (int i = 1; i <= ST; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    typedef struct packed {
        logic       r, en, fc, oc, dd, sd;
        logic [2:0] st;
        logic       la, fl;
        logic [1:0] code;
        logic       dp, sp;
    } vec_t;

    vec_t tbl [16];

    initial begin
        int fault_at, pulse_at;
        tbl = '{
            '{1,0,0,0,0,0, 3'd0, 0,0, 2'b00, 0,0},
            '{0,1,0,0,0,0, 3'd1, 0,0, 2'b00, 0,0},
            '{0,1,0,0,0,0, 3'd2, 0,0, 2'b00, 1,0},
            '{0,1,0,0,0,0, 3'd2, 0,0, 2'b00, 0,0},
            '{0,1,0,0,1,0, 3'd3, 0,0, 2'b00, 0,0},
            '{0,1,0,0,0,0, 3'd4, 0,0, 2'b00, 0,1},
            '{0,1,0,0,0,1, 3'd5, 0,0, 2'b00, 0,0},
            '{0,1,0,0,0,0, 3'd5, 0,0, 2'b00, 0,0},
            '{0,0,0,0,0,0, 3'd0, 0,0, 2'b00, 0,0},
            '{0,0,0,1,0,0, 3'd7, 0,1, 2'b01, 0,0},
            '{0,0,1,1,0,0, 3'd7, 0,1, 2'b01, 0,0},
            '{0,1,1,0,0,0, 3'd7, 0,1, 2'b01, 0,0},
            '{0,0,1,0,0,0, 3'd0, 0,0, 2'b00, 0,0},
            '{0,0,0,0,1,1, 3'd0, 0,0, 2'b00, 0,0},
            '{0,1,0,1,0,0, 3'd7, 0,1, 2'b01, 0,0},
            '{1,0,0,0,0,0, 3'd0, 0,0, 2'b00, 0,0}
        };
        for (int i = 0; i < 16; i++) begin
            cycle(tbl[i].r, tbl[i].en, tbl[i].fc, tbl[i].oc, tbl[i].dd, tbl[i].sd);
            chk($sformatf("table[%0d]", i),
                int'({laser_enable, fault_latched, fault_code, seq_state, dac_update_req, dds_update_req}),
                int'({tbl[i].la, tbl[i].fl, tbl[i].code, tbl[i].st, tbl[i].dp, tbl[i].sp}));
        end

        // nominal turn-on: laser exactly ST edges after dds_done
        do_reset();
        for (int i = 1; i <= 7; i++) begin
            step(1'b1, 1'b0, 1'b0, i == 5, i == 7);
            if (i == 2) chk("dac_req_latency", int'(dac_update_req), 1);
        end
        for (int i = 1; i <= ST; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            if (i == ST - 1) chk("laser_before_settle", int'(laser_enable), 0);
        end
        chk("laser_after_settle", int'(laser_enable), 1);
        chk("active_state", int'(seq_state), 6);
        chk("dac_pulses", n_dacp, 1);
        chk("dds_pulses", n_ddsp, 1);

        // DAC timeout: fault TO edges after the dac_update_req pulse
        do_reset();
        fault_at = -1; pulse_at = -1;
        for (int i = 1; i <= TO + 6; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            if (dac_update_req && pulse_at < 0) pulse_at = i;
            if (fault_latched && fault_at < 0) fault_at = i;
        end
        chk("dac_timeout_delay", fault_at - pulse_at, TO);
        chk("dac_timeout_code", int'(fault_code), 2);
        chk("dac_timeout_laser", int'(laser_enable), 0);
        chk("dac_timeout_no_dds", n_ddsp, 0);

        // over-current while ACTIVE, then clear handshake
        do_reset();
        go_active();
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("oc_laser_drop", int'(laser_enable), 0);
        chk("oc_code", int'(fault_code), 1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("clear_ignored_en", int'(seq_state), 7);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("no_clear_stays", int'(seq_state), 7);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("clear_to_idle", int'(seq_state), 0);
        chk("clear_code", int'(fault_code), 0);

        // dac_done on the timeout edge wins, then dds_done with over_current faults as over-current
        do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k < TO; k++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("done_beats_timeout", int'(seq_state), 3);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("oc_beats_done_state", int'(seq_state), 7);
        chk("oc_beats_done_code", int'(fault_code), 1);

        // abort in SETTLE
        do_reset();
        for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 1'b0, i == 3, i == 5);
        chk("in_settle", int'(seq_state), 5);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("abort_idle", int'(seq_state), 0);
        chk("abort_no_fault", int'({fault_latched, fault_code}), 0);

        // reset in WAIT_DDS, late dds_done ignored
        do_reset();
        for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, 1'b0, i == 3, 1'b0);
        chk("in_wait_dds", int'(seq_state), 4);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset_outputs", int'({laser_enable, fault_latched, fault_code, seq_state, dac_update_req, dds_update_req}), 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("late_dds_ignored", int'(seq_state), 0);

        // random stimulus against the model
        for (int i = 0; i < 4000; i++) begin
            int en_bias;
            en_bias = ((i / 250) % 2 == 0) ? 97 : 60;
            cycle($urandom_range(999) < 3,
                  $urandom_range(99) < en_bias,
                  $urandom_range(99) < 10,
                  $urandom_range(99) < 2,
                  $urandom_range(99) < 15,
                  $urandom_range(99) < 15);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
